mac_seq: RTL

Multi-cycle multiply/multiply-accumulate sequencer for the ARM7TDMI execute stage. It accepts one MUL/MLA/UMULL/UMLAL/SMULL/SMLAL operation from decode and iterates 8 bits of the Rs multiplier per cycle over a 64-bit accumulator. Iteration stops early when the remaining multiplier bits are redundant, giving 1-4 iteration cycles. It returns a 32- or 64-bit result plus N/Z flag updates for CPSR writeback.

---
 rtl/mac_pkg.sv | 51 +++++
 rtl/mac_seq_if.sv | 30 +++
 rtl/mac_partial.sv | 19 +
 rtl/mac_seq.sv | 100 ++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types for the multiply/accumulate sequencer: op encoding, FSM states, latched context.
// Also holds the early-termination test used on each iteration step.
package mac_pkg;

  localparam int OP_W          = 3;
  localparam int OP_LONG_BIT   = 2;
  localparam int OP_SIGNED_BIT = 1;
  localparam int OP_ACC_BIT    = 0;

  typedef enum logic [OP_W-1:0] {
    OP_MUL   = 3'b000,
    OP_MLA   = 3'b001,
    OP_UMULL = 3'b100,
    OP_UMLAL = 3'b101,
    OP_SMULL = 3'b110,
    OP_SMLAL = 3'b111
  } mac_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    mac_op_t     op;
    logic        set_flags;
    logic [31:0] rs;
    logic [63:0] rm_ext;
  } ctx_t;

  // True when the multiplier bits above the current byte carry no information.
  function automatic logic step_term(input logic [31:0] rs, input logic [1:0] idx,
                                     input logic sgn);
    logic [5:0]  amt_s;
    logic [5:0]  amt_u;
    logic [31:0] sh_s;
    logic [31:0] sh_u;
    amt_s = {1'b0, idx, 3'b000} + 6'd7;
    amt_u = {1'b0, idx, 3'b000} + 6'd8;
    sh_s  = $unsigned($signed(rs) >>> amt_s);
    sh_u  = rs >> amt_u;
    if (idx == 2'd3)
      return 1'b1;
    else if (sgn)
      return (sh_s == 32'd0) || (sh_s == 32'hFFFF_FFFF);
    else
      return sh_u == 32'd0;
  endfunction

endpackage

// File: rtl/mac_seq_if.sv
// Request/result bundle between decode/writeback (master) and the MAC sequencer (slave).
interface mac_seq_if;
  import mac_pkg::*;

  logic        req;
  logic        ready;
  mac_op_t     op;
  logic        set_flags;
  logic [31:0] rm;
  logic [31:0] rs;
  logic [31:0] rn_lo;
  logic [31:0] rn_hi;
  logic        flush;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        flag_we;
  logic        n_flag;
  logic        z_flag;

  modport master (
    output req, op, set_flags, rm, rs, rn_lo, rn_hi, flush,
    input  ready, done, result_lo, result_hi, flag_we, n_flag, z_flag
  );

  modport slave (
    input  req, op, set_flags, rm, rs, rn_lo, rn_hi, flush,
    output ready, done, result_lo, result_hi, flag_we, n_flag, z_flag
  );
endinterface

// File: rtl/mac_partial.sv
// One iteration of the MAC: acc + (rm_ext * byte) << 8*idx, modulo 2^64.
// Purely combinational; no flow control.
module mac_partial (
  input  logic [63:0] acc,
  input  logic [63:0] rm_ext,
  input  logic [7:0]  mbyte,
  input  logic        mbyte_signed,
  input  logic [1:0]  idx,
  output logic [63:0] sum
);
  logic [63:0] b_ext;
  logic [63:0] prod;

  always_comb begin
    b_ext = mbyte_signed ? {{56{mbyte[7]}}, mbyte} : {56'd0, mbyte};
    prod  = rm_ext * b_ext;
    sum   = acc + (prod << {idx, 3'b000});
  end
endmodule

// File: rtl/mac_seq.sv
// Multi-cycle MUL/MLA/[US]MULL/[US]MLAL sequencer, 8 multiplier bits per cycle, 1-4 iterations.
// Latency k+1 cycles from accept to done; ready only in IDLE, so requests while busy stall.
module mac_seq
  import mac_pkg::*;
(
  input logic    clk,
  input logic    rst,
  mac_seq_if.slave bus
);
  state_t      state_q, state_d;
  ctx_t        ctx_q;
  logic [63:0] acc_q;
  logic [1:0]  idx_q;
  logic        ready, accept, term, is_long, signed_mode;
  logic [7:0]  byte_sel;
  logic [63:0] acc_sum;
  logic        done_q, n_q, z_q;
  logic [31:0] res_lo_q, res_hi_q;

  assign is_long     = ctx_q.op[OP_LONG_BIT];
  assign signed_mode = !is_long || ctx_q.op[OP_SIGNED_BIT];
  assign byte_sel    = ctx_q.rs[{idx_q, 3'b000} +: 8];
  assign term        = step_term(ctx_q.rs, idx_q, signed_mode);

  // The terminating byte absorbs the sign of all higher bits in signed mode.
  mac_partial u_partial (
    .acc          (acc_q),
    .rm_ext       (ctx_q.rm_ext),
    .mbyte        (byte_sel),
    .mbyte_signed (signed_mode && term),
    .idx          (idx_q),
    .sum          (acc_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ITER;
      ITER:    if (bus.flush) state_d = IDLE;
               else if (term) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready  = (state_q == IDLE);
    accept = ready && bus.req && !bus.flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        ctx_q.op        <= bus.op;
        ctx_q.set_flags <= bus.set_flags;
        ctx_q.rs        <= bus.rs;
        ctx_q.rm_ext    <= (bus.op[OP_LONG_BIT] && bus.op[OP_SIGNED_BIT]) ?
                           {{32{bus.rm[31]}}, bus.rm} : {32'd0, bus.rm};
        if (bus.op[OP_ACC_BIT])
          acc_q <= bus.op[OP_LONG_BIT] ? {bus.rn_hi, bus.rn_lo} : {32'd0, bus.rn_lo};
        else
          acc_q <= '0;
        idx_q <= '0;
      end else if (state_q == ITER && !bus.flush) begin
        acc_q <= acc_sum;
        idx_q <= idx_q + 2'd1;
        if (term) begin
          done_q   <= 1'b1;
          res_lo_q <= acc_sum[31:0];
          res_hi_q <= is_long ? acc_sum[63:32] : 32'd0;
          n_q      <= is_long ? acc_sum[63] : acc_sum[31];
          z_q      <= is_long ? (acc_sum == 64'd0) : (acc_sum[31:0] == 32'd0);
        end
      end
    end
  end

  assign bus.ready     = ready;
  assign bus.done      = done_q;
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.n_flag    = n_q;
  assign bus.z_flag    = z_q;
  assign bus.flag_we   = done_q && ctx_q.set_flags;
endmodule
